icache_refill: RTL and testbench

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_refill_pkg.sv | 23 ++
 rtl/icache_refill_if.sv | 29 ++
 rtl/icache_refill_inst_assembler.sv | 21 ++
 rtl/icache_refill.sv | 101 ++++++++++
 tb/tb_icache_refill.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_refill_pkg.sv
// Shared constants for the icache refill engine: bus widths, refill size, FSM encodings.
// Legacy defines InstAddrBus/BlockNum are kept for older RTL that still uses them.
`ifndef InstAddrBus
`define InstAddrBus 16:0
`endif
`ifndef BlockNum
`define BlockNum 32768
`endif

package icache_refill_pkg;
  localparam int REFILL_BYTES = 4;
  localparam int INST_ADDR_W  = 17;
  localparam int BLOCK_NUM    = `BlockNum;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/icache_refill_if.sv
// Core/memory/icache-side signal bundle of the refill engine.
// slave = refill engine view, master = surrounding core/memory/test view.
interface icache_refill_if;
  import icache_refill_pkg::*;

  logic                   req_i;
  logic [31:0]            addr_i;
  logic                   flush_i;
  logic                   busy_o;
  logic                   valid_o;
  logic [31:0]            inst_o;
  logic                   mem_gnt_i;
  logic                   mem_req_o;
  logic [31:0]            mem_a_o;
  logic [7:0]             mem_din_i;
  logic                   we_o;
  logic [INST_ADDR_W-1:0] waddr_o;
  logic [31:0]            winst_o;

  modport slave (
    input  req_i, addr_i, flush_i, mem_gnt_i, mem_din_i,
    output busy_o, valid_o, inst_o, mem_req_o, mem_a_o, we_o, waddr_o, winst_o
  );

  modport master (
    output req_i, addr_i, flush_i, mem_gnt_i, mem_din_i,
    input  busy_o, valid_o, inst_o, mem_req_o, mem_a_o, we_o, waddr_o, winst_o
  );
endinterface

// File: rtl/icache_refill_inst_assembler.sv
// Little-endian byte assembler: each enabled byte shifts in at the top, so after
// NBYTES captures word = {bN-1,...,b1,b0}. word_nxt is the word including din.
module inst_assembler #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [7:0]          din,
  output logic [NBYTES*8-1:0] word,
  output logic [NBYTES*8-1:0] word_nxt
);
  assign word_nxt = {din, word[NBYTES*8-1:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      word <= '0;
    else if (clr) word <= '0;
    else if (en)  word <= word_nxt;
  end
endmodule

// File: rtl/icache_refill.sv
// Icache miss refill: fetches one 32-bit instruction as four byte reads and writes it
// to the icache. Define REFILL_BYPASS_EN to write in DRAIN using the live top byte.
module icache_refill
  import icache_refill_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  icache_refill_if.slave bus
);
  logic [1:0]             state;
  logic [1:0]             cnt;
  logic [31:0]            base;
  logic [31:0]            mem_a_q;
  logic [31:0]            inst_q;
  logic [INST_ADDR_W-1:0] waddr_q;
  logic [31:0]            asm_word;
  logic [31:0]            asm_nxt;
  logic [31:0]            out_word;
  logic                   start;
  logic                   capture;
  logic                   in_last;

`ifdef REFILL_BYPASS_EN
  // The top byte is still on mem_din_i during DRAIN, so the word is taken look-through.
  localparam logic [1:0] S_LAST = S_DRAIN;
  logic unused_word;
  assign out_word    = asm_nxt;
  assign unused_word = ^asm_word;
`else
  localparam logic [1:0] S_LAST = S_DONE;
  logic unused_nxt;
  assign out_word   = asm_word;
  assign unused_nxt = ^asm_nxt;
`endif

  assign start   = (state == S_IDLE) && bus.req_i && bus.mem_gnt_i && !bus.flush_i;
  // Read data trails its address by a cycle, so byte k lands one cycle after address k.
  assign capture = ((state == S_ISSUE) && (cnt != 2'd0)) || (state == S_DRAIN);
  assign in_last = (state == S_LAST);

  inst_assembler #(.NBYTES(REFILL_BYTES)) u_asm (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy && capture && !bus.flush_i),
    .clr      (rdy && start),
    .din      (bus.mem_din_i),
    .word     (asm_word),
    .word_nxt (asm_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      base    <= '0;
      mem_a_q <= '0;
      waddr_q <= '0;
      inst_q  <= '0;
    end else if (rdy) begin
      if (bus.flush_i) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        if (in_last) inst_q <= out_word;
        case (state)
          S_IDLE: begin
            if (start) begin
              base    <= word_align(bus.addr_i);
              mem_a_q <= word_align(bus.addr_i);
              cnt     <= '0;
              state   <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state   <= S_DRAIN;
              waddr_q <= base[INST_ADDR_W-1:0];
            end else begin
              mem_a_q <= base + {30'd0, cnt} + 32'd1;
            end
          end
          S_DRAIN: state <= (S_LAST == S_DRAIN) ? S_IDLE : S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Outside a refill the bus request simply mirrors the miss; ownership is unconditional once issued.
  assign bus.mem_req_o = !rst && ((state == S_IDLE) ? bus.req_i
                                                     : ((state == S_ISSUE) || (state == S_DRAIN)));
  assign bus.mem_a_o   = mem_a_q;
  assign bus.busy_o    = (state != S_IDLE);
  assign bus.we_o      = in_last && !bus.flush_i;
  assign bus.valid_o   = in_last && !bus.flush_i;
  assign bus.inst_o    = in_last ? out_word : inst_q;
  assign bus.winst_o   = in_last ? out_word : inst_q;
  assign bus.waddr_o   = waddr_q;
endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed scenarios plus randomized refills with stalls.
module tb_icache_refill;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  icache_refill_if bus();

  icache_refill dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

`ifdef REFILL_BYPASS_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 6;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: explicit overrides, otherwise a fixed hash of the byte address.
  bit [7:0] ovr [bit [31:0]];

  function automatic bit [7:0] mbyte(input bit [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return 8'(a ^ (a >> 8) ^ (a >> 19)) ^ 8'h5A;
  endfunction

  function automatic bit [31:0] exp_word(input bit [31:0] addr);
    bit [31:0] b;
    b = addr & ~32'd3;
    return {mbyte(b + 32'd3), mbyte(b + 32'd2), mbyte(b + 32'd1), mbyte(b)};
  endfunction

  // Byte memory answers one cycle after the address and stalls with rdy.
  always @(posedge clk) if (rdy) bus.mem_din_i <= mbyte(bus.mem_a_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_we(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (bus.we_o === 1'b1) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1;
    bus.req_i = 1'b0; bus.flush_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.addr_i = '0;
    repeat (3) tick();
    n_tests++;
    if ({bus.busy_o, bus.valid_o, bus.we_o, bus.mem_req_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus.busy_o, bus.valid_o, bus.we_o, bus.mem_req_o});
    end
    n_tests++;
    if (bus.mem_a_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h expected 0", bus.mem_a_o); end
    n_tests++;
    if (bus.inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", bus.inst_o); end
    n_tests++;
    if (bus.winst_o !== 32'h0) begin n_fail++; $display("FAIL reset_winst: got %h expected 0", bus.winst_o); end
    n_tests++;
    if (bus.waddr_o !== 17'h0) begin n_fail++; $display("FAIL reset_waddr: got %h expected 0", bus.waddr_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int t0, at;
    logic [31:0] ea;
    ovr[32'h1004] = 8'h13; ovr[32'h1005] = 8'h05; ovr[32'h1006] = 8'h00; ovr[32'h1007] = 8'h00;
    bus.req_i = 1'b1; bus.mem_gnt_i = 1'b1; bus.addr_i = 32'h0000_1004;
    t0 = cyc;
    #1;
    n_tests++;
    if (bus.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL basic_idle_req: got %b expected 1", bus.mem_req_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) bus.addr_i = 32'hDEAD_BEE0;  // a miss while busy must be ignored
      #1;
      ea = 32'h1004 + 32'(k);
      n_tests++;
      if ({bus.we_o, bus.mem_req_o, bus.busy_o, bus.mem_a_o} !== {1'b0, 1'b1, 1'b1, ea}) begin
        n_fail++; $display("FAIL basic_issue_k%0d: got we/req/busy %b%b%b a=%h expected 011 a=%h",
                           k, bus.we_o, bus.mem_req_o, bus.busy_o, bus.mem_a_o, ea);
      end
    end
    tick();
    bus.req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    wait_we(10, at);
    n_tests++;
    if (at !== t0 + LAT) begin n_fail++; $display("FAIL basic_latency: got cycle %0d expected %0d", at, t0 + LAT); end
    n_tests++;
    if ({bus.waddr_o, bus.winst_o} !== {17'h01004, 32'h0000_0513}) begin
      n_fail++; $display("FAIL basic_write: got %h/%h expected 01004/00000513", bus.waddr_o, bus.winst_o);
    end
    n_tests++;
    if ({bus.valid_o, bus.inst_o} !== {1'b1, 32'h0000_0513}) begin
      n_fail++; $display("FAIL basic_valid: got %b/%h expected 1/00000513", bus.valid_o, bus.inst_o);
    end
    tick();
    n_tests++;
    if ({bus.we_o, bus.valid_o, bus.busy_o, bus.inst_o} !== {3'b000, 32'h0000_0513}) begin
      n_fail++; $display("FAIL basic_after: got %b%b%b %h expected 000 00000513",
                         bus.we_o, bus.valid_o, bus.busy_o, bus.inst_o);
    end
  endtask

  task automatic test_align();
    bit [31:0] addrs [2];
    int t0, at;
    addrs[0] = 32'h0000_100B;
    addrs[1] = 32'hFFFF_FFFE;
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.req_i = 1'b1; bus.mem_gnt_i = 1'b1; bus.addr_i = addrs[i];
      t0 = cyc;
      tick();
      bus.req_i = 1'b0; bus.mem_gnt_i = 1'b0;
      n_tests++;
      if (bus.mem_a_o !== (addrs[i] & ~32'd3)) begin
        n_fail++; $display("FAIL align_first_addr: got %h expected %h", bus.mem_a_o, addrs[i] & ~32'd3);
      end
      wait_we(12, at);
      n_tests++;
      if (at !== t0 + LAT) begin n_fail++; $display("FAIL align_latency: got %0d expected %0d", at, t0 + LAT); end
      n_tests++;
      if ({bus.waddr_o, bus.winst_o} !== {addrs[i][16:0] & 17'h1FFFC, exp_word(addrs[i])}) begin
        n_fail++; $display("FAIL align_write: got %h/%h expected %h/%h", bus.waddr_o, bus.winst_o,
                           addrs[i][16:0] & 17'h1FFFC, exp_word(addrs[i]));
      end
    end
  endtask

  task automatic test_grant();
    int t0, at;
    logic [31:0] a_prev;
    tick();
    bus.req_i = 1'b1; bus.mem_gnt_i = 1'b0; bus.addr_i = 32'h0000_2000;
    #1;
    a_prev = bus.mem_a_o;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({bus.busy_o, bus.mem_req_o, bus.mem_a_o} !== {1'b0, 1'b1, a_prev}) begin
        n_fail++; $display("FAIL grant_wait_%0d: got busy/req %b%b a=%h expected 01 a=%h",
                           i, bus.busy_o, bus.mem_req_o, bus.mem_a_o, a_prev);
      end
      tick();
    end
    bus.mem_gnt_i = 1'b1;
    t0 = cyc;
    tick();
    bus.req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    n_tests++;
    if ({bus.busy_o, bus.mem_a_o} !== {1'b1, 32'h0000_2000}) begin
      n_fail++; $display("FAIL grant_start: got busy %b a=%h expected 1 a=00002000", bus.busy_o, bus.mem_a_o);
    end
    wait_we(12, at);
    n_tests++;
    if ({at, bus.winst_o} !== {t0 + LAT, exp_word(32'h2000)}) begin
      n_fail++; $display("FAIL grant_write: got cycle %0d word %h expected %0d %h", at, bus.winst_o, t0 + LAT, exp_word(32'h2000));
    end
  endtask

  task automatic test_flush();
    int t0, t1, at;
    tick();
    bus.req_i = 1'b1; bus.mem_gnt_i = 1'b1; bus.addr_i = 32'h0000_3000;
    t0 = cyc;
    tick();
    bus.req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    tick();
    tick();
    bus.flush_i = 1'b1;
    #1;
    n_tests++;
    if (bus.we_o !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_we: got %b expected 0", bus.we_o); end
    tick();
    bus.flush_i = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy_o, bus.mem_req_o} !== 2'b00) begin
      n_fail++; $display("FAIL flush_idle: got busy/req %b%b expected 00 (cycle %0d)", bus.busy_o, bus.mem_req_o, cyc - t0);
    end
    tick();
    bus.req_i = 1'b1; bus.mem_gnt_i = 1'b1; bus.addr_i = 32'h0000_3010;
    t1 = cyc;
    tick();
    bus.req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    wait_we(12, at);
    n_tests++;
    if ({at, bus.waddr_o, bus.winst_o} !== {t1 + LAT, 17'h03010, exp_word(32'h3010)}) begin
      n_fail++; $display("FAIL flush_restart: got cycle %0d %h/%h expected %0d 03010/%h",
                         at, bus.waddr_o, bus.winst_o, t1 + LAT, exp_word(32'h3010));
    end
  endtask

  task automatic test_flush_done();
    logic [31:0] prev;
    int seen;
    tick();
    prev = bus.inst_o;
    bus.req_i = 1'b1; bus.mem_gnt_i = 1'b1; bus.addr_i = 32'h0000_4000;
    tick();
    bus.req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    repeat (LAT - 1) tick();
    bus.flush_i = 1'b1;
    #1;
    n_tests++;
    if ({bus.we_o, bus.valid_o} !== 2'b00) begin
      n_fail++; $display("FAIL flush_done_pulse: got we/valid %b%b expected 00", bus.we_o, bus.valid_o);
    end
    tick();
    bus.flush_i = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy_o, bus.inst_o} !== {1'b0, prev}) begin
      n_fail++; $display("FAIL flush_done_hold: got busy %b inst %h expected 0 %h", bus.busy_o, bus.inst_o, prev);
    end
    seen = 0;
    repeat (4) begin
      if (bus.we_o !== 1'b0) seen++;
      tick();
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush_done_late_we: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_stall();
    int t0, at;
    tick();
    bus.req_i = 1'b1; bus.mem_gnt_i = 1'b1; bus.addr_i = 32'h0000_5004;
    t0 = cyc;
    tick();
    bus.req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({bus.busy_o, bus.mem_req_o, bus.we_o, bus.mem_a_o} !== {3'b110, 32'h0000_5005}) begin
        n_fail++; $display("FAIL stall_frozen_%0d: got %b%b%b a=%h expected 110 a=00005005",
                           i, bus.busy_o, bus.mem_req_o, bus.we_o, bus.mem_a_o);
      end
    end
    tick();
    rdy = 1'b1;
    wait_we(15, at);
    n_tests++;
    if ({at, bus.winst_o} !== {t0 + LAT + 3, exp_word(32'h5004)}) begin
      n_fail++; $display("FAIL stall_write: got cycle %0d word %h expected %0d %h", at, bus.winst_o, t0 + LAT + 3, exp_word(32'h5004));
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    tick();
    bus.req_i = 1'b1; bus.mem_gnt_i = 1'b1; bus.addr_i = 32'h0000_6000;
    tick();
    bus.req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.busy_o, bus.mem_req_o, bus.mem_a_o, bus.inst_o} !== {2'b00, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset_mid: got busy/req %b%b a=%h inst=%h expected 00 0 0",
                         bus.busy_o, bus.mem_req_o, bus.mem_a_o, bus.inst_o);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (LAT + 2) begin
      if (bus.we_o !== 1'b0) seen++;
      tick();
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_we: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_random();
    bit [31:0] a;
    int act, guard;
    bit done;
    for (int it = 0; it < 20; it++) begin
      a = $urandom();
      tick();
      bus.req_i = 1'b1; bus.addr_i = a; bus.mem_gnt_i = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      bus.mem_gnt_i = 1'b1;
      tick();
      bus.req_i = 1'b0; bus.mem_gnt_i = 1'b0;
      // The write is due once LAT-1 enabled edges have followed the accepting edge.
      act = 0; done = 1'b0;
      for (guard = 0; guard < 40 && !done; guard++) begin
        if (act == LAT - 1) begin
          rdy = 1'b1;
          n_tests++;
          if ({bus.we_o, bus.waddr_o, bus.winst_o} !== {1'b1, a[16:0] & 17'h1FFFC, exp_word(a)}) begin
            n_fail++; $display("FAIL random_write_%0d: got we %b %h/%h expected 1 %h/%h", it,
                               bus.we_o, bus.waddr_o, bus.winst_o, a[16:0] & 17'h1FFFC, exp_word(a));
          end
          done = 1'b1;
        end else begin
          n_tests++;
          if (bus.we_o !== 1'b0) begin n_fail++; $display("FAIL random_early_we_%0d: got 1 expected 0 at step %0d", it, act); end
          rdy = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
          if (rdy) act++;
          tick();
        end
      end
      if (!done) begin
        n_tests++; n_fail++;
        $display("FAIL random_timeout_%0d: got no write expected one", it);
      end
      rdy = 1'b1;
      tick();
      n_tests++;
      if ({bus.busy_o, bus.inst_o} !== {1'b0, exp_word(a)}) begin
        n_fail++; $display("FAIL random_hold_%0d: got busy %b inst %h expected 0 %h", it, bus.busy_o, bus.inst_o, exp_word(a));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_align();
    test_grant();
    test_flush();
    test_flush_done();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end
endmodule
